// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin issue scheduler for the 5-bit ALU with a credit-protected in-order response buffer.
module alu_sched #(
  parameter int REQ_DEPTH = 2,
  parameter int RES_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0][1:0] req_mode,
  input  logic [1:0][2:0] req_op,
  input  logic [1:0][4:0] req_a,
  input  logic [1:0][4:0] req_b,
  output logic            alu_a_en,
  output logic            alu_b_en,
  output logic [2:0]      alu_a_op,
  output logic [1:0]      alu_b_op,
  output logic [4:0]      alu_A,
  output logic [4:0]      alu_B,
  input  logic [5:0]      alu_C,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [5:0]      rsp_c,
  output logic            rsp_err
);
  localparam int AW = $clog2(REQ_DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  logic [1:0] ne, push, pop;
  logic [1:0][14:0] head;
  logic gnt, credit, issue, last_q;
  logic [14:0] sel, alu_q, alu_d;
  logic [RW+1:0] occ;
  logic s1_v_q, s1_id_q, s1_err_q, s2_v_q, s2_id_q, s2_err_q;
  logic [7:0] rb_q [RES_DEPTH];
  logic [RW-1:0] rwr_q, rrd_q;
  logic [RW:0] rcnt_q;
  logic cap, rpop;
  // Entry layout: {mode[1:0], op[2:0], a[4:0], b[4:0]}
  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [14:0] mem_q [REQ_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    assign ne[i] = cnt_q != '0;
    assign req_ready[i] = !rst && cnt_q != (AW+1)'(REQ_DEPTH);
    assign push[i] = req_valid[i] && req_ready[i];
    assign head[i] = mem_q[rd_q];
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q <= '0;
        rd_q <= '0;
        cnt_q <= '0;
      end else begin
        if (push[i]) begin
          mem_q[wr_q] <= {req_mode[i], req_op[i], req_a[i], req_b[i]};
          wr_q <= wr_q + 1'b1;
        end
        if (pop[i]) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
    end
  end
  // Credit covers everything that will land in the response buffer.
  always_comb begin
    gnt = (&ne) ? ~last_q : ne[1];
    occ = (RW+2)'(rcnt_q) + (RW+2)'(s1_v_q) + (RW+2)'(s2_v_q);
    credit = occ < (RW+2)'(RES_DEPTH);
    issue = |ne && credit;
    pop = issue ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    sel = head[gnt];
    alu_d = issue ? sel : '0;
  end
  assign {alu_b_en, alu_a_en, alu_a_op, alu_A, alu_B} = alu_q;
  assign alu_b_op = alu_q[11:10];
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q <= '0;
      s1_v_q <= 1'b0;
      s1_id_q <= 1'b0;
      s1_err_q <= 1'b0;
      s2_v_q <= 1'b0;
      s2_id_q <= 1'b0;
      s2_err_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      alu_q <= alu_d;
      s1_v_q <= issue;
      s1_id_q <= gnt;
      s1_err_q <= sel[14:13] == 2'b00;
      s2_v_q <= s1_v_q;
      s2_id_q <= s1_id_q;
      s2_err_q <= s1_err_q;
      if (issue) last_q <= gnt;
    end
  end
  function automatic logic [RW-1:0] rnext(input logic [RW-1:0] p);
    return (p == RW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign cap = s2_v_q;
  assign rsp_valid = rcnt_q != '0;
  assign rpop = rsp_valid && rsp_ready;
  assign {rsp_id, rsp_c, rsp_err} = rsp_valid ? rb_q[rrd_q] : 8'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rwr_q <= '0;
      rrd_q <= '0;
      rcnt_q <= '0;
    end else begin
      if (cap) begin
        rb_q[rwr_q] <= {s2_id_q, s2_err_q ? 6'd0 : alu_C, s2_err_q};
        rwr_q <= rnext(rwr_q);
      end
      if (rpop) rrd_q <= rnext(rrd_q);
      rcnt_q <= rcnt_q + (RW+1)'(cap) - (RW+1)'(rpop);
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench for alu_sched with a registered ALU model driving alu_C.
module tb_alu_sched;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready;
  logic [1:0][1:0] req_mode;
  logic [1:0][2:0] req_op;
  logic [1:0][4:0] req_a, req_b;
  logic alu_a_en, alu_b_en;
  logic [2:0] alu_a_op;
  logic [1:0] alu_b_op;
  logic [4:0] alu_A, alu_B;
  logic [5:0] alu_C;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [5:0] rsp_c;
  int ncmp = 0, nfail = 0, cyc = 0;
  logic [7:0] rq [$];
  logic [4:0] iq [$];
  int it [$];

  alu_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a_en(alu_a_en), .alu_b_en(alu_b_en), .alu_a_op(alu_a_op), .alu_b_op(alu_b_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_C(alu_C),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ALU contract: add/sub sign-extend, SUBONE/ADDTWO on B2 mode, logic ops zero-extend; idle drives junk.
  function automatic logic [5:0] alu_f(input logic ae, input logic be, input logic [2:0] aop,
                                       input logic [1:0] bop, input logic [4:0] a, input logic [4:0] b);
    logic [5:0] sa, sb;
    sa = {a[4], a};
    sb = {b[4], b};
    if ({be, ae} == 2'b01) begin
      case (aop)
        3'd0: return sa + sb;
        3'd1: return sa - sb;
        3'd2: return {1'b0, a & b};
        3'd3: return {1'b0, a | b};
        default: return {1'b0, a ^ b};
      endcase
    end else if ({be, ae} == 2'b10) begin
      return {1'b0, ~a};
    end else if ({be, ae} == 2'b11) begin
      return (bop == 2'd0) ? sa - 6'd1 : (bop == 2'd1) ? sb + 6'd2 : 6'd0;
    end
    return 6'h2A;
  endfunction

  always @(posedge clk) alu_C <= alu_f(alu_a_en, alu_b_en, alu_a_op, alu_b_op, alu_A, alu_B);
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst && rsp_valid && rsp_ready) rq.push_back({rsp_id, rsp_c, rsp_err});
  always @(negedge clk) if (alu_a_en || alu_b_en) begin
    iq.push_back(alu_A);
    it.push_back(cyc);
  end

  function automatic logic [31:0] pk(input logic id, input logic [5:0] c, input logic e);
    return {24'd0, id, c, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] exp);
    logic [31:0] o;
    o = 32'hDEAD;
    if (rq.size() != 0) o = {24'd0, rq.pop_front()};
    chk(tag, o, exp);
  endtask

  task automatic chk_iss(input string tag, input logic [4:0] exp);
    logic [31:0] o;
    o = 32'hDEAD;
    if (iq.size() != 0) o = {27'd0, iq.pop_front()};
    chk(tag, o, {27'd0, exp});
  endtask

  task automatic send(input int i, input logic [1:0] m, input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
    int t;
    t = 0;
    req_mode[i] = m;
    req_op[i] = op;
    req_a[i] = a;
    req_b[i] = b;
    req_valid[i] = 1'b1;
    while (!req_ready[i] && t < 50) begin
      tick();
      t++;
    end
    chk("send_ready", {31'd0, t < 50}, 32'd1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic stream(input int n, input int a0, input int a1, input logic [4:0] b);
    int k0, k1, t;
    logic [1:0] r;
    k0 = 0;
    k1 = 0;
    t = 0;
    while ((k0 < n || k1 < n) && t < 60) begin
      req_valid = {k1 < n, k0 < n};
      req_mode = {2'b01, 2'b01};
      req_op = '0;
      req_a[0] = 5'(a0 + k0);
      req_a[1] = 5'(a1 + k1);
      req_b = {b, b};
      r = req_ready & req_valid;
      tick();
      k0 += int'(r[0]);
      k1 += int'(r[1]);
      t++;
    end
    req_valid = '0;
    chk("stream_done", {31'd0, t < 60}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_mode = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_en", {30'd0, alu_b_en, alu_a_en}, 32'd0);
    chk("rst_alu_ab", {22'd0, alu_A, alu_B}, 32'd0);
    chk("rst_rsp", {23'd0, rsp_valid, rsp_id, rsp_c, rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {30'd0, req_ready}, 32'd3);

    send(0, 2'b01, 3'd0, 5'h0F, 5'h01);
    chk("add_e0_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("add_e1_en", {30'd0, alu_b_en, alu_a_en}, 32'd1);
    chk("add_e1_ab", {22'd0, alu_A, alu_B}, {22'd0, 5'h0F, 5'h01});
    tick();
    chk("add_e2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("add_e3_rsp", {23'd0, rsp_valid, rsp_id, rsp_c, rsp_err}, {23'd0, 1'b1, 1'b0, 6'h10, 1'b0});
    tick();
    chk("add_e4_popped", {31'd0, rsp_valid}, 32'd0);
    rq.delete();

    send(1, 2'b01, 3'd0, 5'h10, 5'h1F);
    send(1, 2'b11, 3'd0, 5'h00, 5'h00);
    send(1, 2'b11, 3'd1, 5'h00, 5'h1F);
    repeat (6) tick();
    chk_rsp("sext_add", pk(1'b1, 6'h2F, 1'b0));
    chk_rsp("sext_subone", pk(1'b1, 6'h3F, 1'b0));
    chk_rsp("sext_addtwo", pk(1'b1, 6'h01, 1'b0));

    iq.delete();
    it.delete();
    rq.delete();
    stream(4, 1, 9, 5'd0);
    repeat (8) tick();
    chk("rr_issue_count", iq.size(), 32'd8);
    chk("rr_issue_span", (it.size() == 8) ? it[7] - it[0] : -1, 32'd7);
    for (int k = 0; k < 4; k++) begin
      chk_iss("rr_issue_r0", 5'(1 + k));
      chk_iss("rr_issue_r1", 5'(9 + k));
    end
    for (int k = 0; k < 4; k++) begin
      chk_rsp("rr_rsp_r0", pk(1'b0, 6'(1 + k), 1'b0));
      chk_rsp("rr_rsp_r1", pk(1'b1, 6'(9 + k), 1'b0));
    end

    iq.delete();
    rq.delete();
    rsp_ready = 1'b0;
    stream(4, 2, 10, 5'd1);
    repeat (5) tick();
    chk("bp_issue_count", iq.size(), 32'd4);
    chk("bp_en_stalled", {30'd0, alu_b_en, alu_a_en}, 32'd0);
    chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
    chk("bp_head", {23'd0, rsp_valid, rsp_id, rsp_c, rsp_err}, {23'd0, 1'b1, 1'b0, 6'd3, 1'b0});
    chk("bp_no_pops", rq.size(), 32'd0);
    rsp_ready = 1'b1;
    repeat (20) tick();
    chk("bp_total_issues", iq.size(), 32'd8);
    chk("bp_total_rsp", rq.size(), 32'd8);
    for (int k = 0; k < 4; k++) begin
      chk_iss("bp_issue_r0", 5'(2 + k));
      chk_iss("bp_issue_r1", 5'(10 + k));
    end
    for (int k = 0; k < 4; k++) begin
      chk_rsp("bp_rsp_r0", pk(1'b0, 6'(3 + k), 1'b0));
      chk_rsp("bp_rsp_r1", pk(1'b1, 6'(11 + k), 1'b0));
    end
    chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

    rq.delete();
    send(0, 2'b01, 3'd0, 5'd1, 5'd1);
    send(0, 2'b00, 3'd0, 5'd7, 5'd7);
    chk("ill_prev_issue", {25'd0, alu_b_en, alu_a_en, alu_A}, {25'd0, 2'b01, 5'd1});
    send(0, 2'b01, 3'd0, 5'd2, 5'd2);
    chk("ill_issue_en", {30'd0, alu_b_en, alu_a_en}, 32'd0);
    tick();
    chk("ill_next_issue", {25'd0, alu_b_en, alu_a_en, alu_A}, {25'd0, 2'b01, 5'd2});
    repeat (5) tick();
    chk_rsp("ill_rsp_before", pk(1'b0, 6'd2, 1'b0));
    chk_rsp("ill_rsp_err", pk(1'b0, 6'd0, 1'b1));
    chk_rsp("ill_rsp_after", pk(1'b0, 6'd4, 1'b0));

    rsp_ready = 1'b0;
    rq.delete();
    send(0, 2'b01, 3'd0, 5'd1, 5'd1);
    send(0, 2'b01, 3'd0, 5'd2, 5'd2);
    send(0, 2'b01, 3'd0, 5'd3, 5'd3);
    tick();
    chk("mid_pre_valid", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_en", {30'd0, alu_b_en, alu_a_en}, 32'd0);
    chk("mid_req_ready", {30'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_release_ready", {30'd0, req_ready}, 32'd3);
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("mid_no_stale", rq.size(), 32'd0);
    chk("mid_still_empty", {31'd0, rsp_valid}, 32'd0);
    iq.delete();
    stream(1, 6, 14, 5'd0);
    repeat (5) tick();
    chk_iss("mid_first_grant", 5'd6);
    chk_iss("mid_second_grant", 5'd14);
    chk_rsp("mid_rsp0", pk(1'b0, 6'd6, 1'b0));
    chk_rsp("mid_rsp1", pk(1'b1, 6'd14, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
